// File: rtl/mem_rr_scheduler.sv
// Round-robin scheduler sharing one registered memory port between instruction and data
// requesters, with one-entry pending buffers and a watchdog that aborts stalled transactions.

package mem_rr_pkg;
    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;
endpackage

module mem_rr_scheduler
    import mem_rr_pkg::*;
#(
    parameter int          TIMEOUT   = 255,
    parameter int          CNT_W     = 8,
    parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    output logic        memory_valid,
    output logic        memory_instr,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_wdata,
    output logic [3:0]  memory_wstrb,
    input  logic [31:0] memory_rdata,
    input  logic        memory_ready,
    output logic        bus_error,
    output logic        overrun
);
    typedef enum logic {ST_IDLE, ST_BUSY} state_e;
    typedef enum logic {PORT_INSTR, PORT_DATA} port_e;

    localparam logic             WD_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e           state_q, state_d;
    port_e            owner_q, owner_d;
    port_e            last_owner_q, last_owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_in_type       ibuf_q, ibuf_d;
    mem_in_type       dbuf_q, dbuf_d;
    mem_in_type       req_q, req_d;
    logic             overrun_q, overrun_d;

    logic  done, abort, i_fin, d_fin, i_cap, d_cap, i_cand, d_cand;
    port_e winner;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        ibuf_d       = ibuf_q;
        dbuf_d       = dbuf_q;
        req_d        = req_q;
        overrun_d    = overrun_q;
        imem_out     = '0;
        dmem_out     = '0;

        done   = (state_q == ST_BUSY) && memory_ready;
        abort  = WD_EN && (state_q == ST_BUSY) && !memory_ready && (cnt_q == CNT_LAST);
        i_fin  = (done || abort) && (owner_q == PORT_INSTR);
        d_fin  = (done || abort) && (owner_q == PORT_DATA);
        i_cap  = imem_in.mem_valid && (!ibuf_q.mem_valid || i_fin);
        d_cap  = dmem_in.mem_valid && (!dbuf_q.mem_valid || d_fin);
        bus_error = abort;

        if (imem_in.mem_valid && !i_cap) overrun_d = 1'b1;
        if (dmem_in.mem_valid && !d_cap) overrun_d = 1'b1;

        // A buffer freed by completion may be refilled by a request arriving in the same cycle.
        if (i_fin) ibuf_d.mem_valid = 1'b0;
        if (d_fin) dbuf_d.mem_valid = 1'b0;
        if (i_cap) ibuf_d = imem_in;
        if (d_cap) dbuf_d = dmem_in;

        i_cand = ibuf_d.mem_valid;
        d_cand = dbuf_d.mem_valid;
        winner = PORT_INSTR;
        if (i_cand && d_cand) winner = (last_owner_q == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
        else if (d_cand)      winner = PORT_DATA;

        if (i_fin) begin
            imem_out.mem_ready = 1'b1;
            imem_out.mem_rdata = abort ? ERR_RDATA : memory_rdata;
        end
        if (d_fin) begin
            dmem_out.mem_ready = 1'b1;
            dmem_out.mem_rdata = abort ? ERR_RDATA : memory_rdata;
        end

        if (state_q == ST_BUSY && !done && !abort && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;

        if (abort) begin
            req_d.mem_valid = 1'b0;
            state_d         = ST_IDLE;
        end else if (state_q == ST_IDLE || done) begin
            if (i_cand || d_cand) begin
                req_d        = (winner == PORT_DATA) ? dbuf_d : ibuf_d;
                owner_d      = winner;
                last_owner_d = winner;
                cnt_d        = '0;
                state_d      = ST_BUSY;
            end else if (done) begin
                req_d.mem_valid = 1'b0;
                state_d         = ST_IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= PORT_INSTR;
            last_owner_q <= PORT_INSTR;
            cnt_q        <= '0;
            ibuf_q       <= '0;
            dbuf_q       <= '0;
            req_q        <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            ibuf_q       <= ibuf_d;
            dbuf_q       <= dbuf_d;
            req_q        <= req_d;
            overrun_q    <= overrun_d;
        end
    end

    assign memory_valid = req_q.mem_valid;
    assign memory_instr = req_q.mem_instr;
    assign memory_addr  = req_q.mem_addr;
    assign memory_wdata = req_q.mem_wdata;
    assign memory_wstrb = req_q.mem_wstrb;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_mem_rr_scheduler.sv
// Scoreboard bench: stimulus queues expected memory issues and responses, a negedge monitor
// pops and compares them. Instance dut uses a long watchdog; dut_wd uses TIMEOUT=4.
module tb_mem_rr_scheduler;
    import mem_rr_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    mem_in_type  imem_in, dmem_in, w_imem_in, w_dmem_in;
    mem_out_type imem_out, dmem_out, w_imem_out, w_dmem_out;
    logic        memory_valid, memory_instr, memory_ready, bus_error, overrun;
    logic [31:0] memory_addr, memory_wdata, memory_rdata;
    logic [3:0]  memory_wstrb;
    logic        w_memory_valid, w_memory_instr, w_memory_ready, w_bus_error, w_overrun;
    logic [31:0] w_memory_addr, w_memory_wdata, w_memory_rdata;
    logic [3:0]  w_memory_wstrb;

    always #5 clock = ~clock;

    mem_rr_scheduler #(.TIMEOUT(16), .CNT_W(8), .ERR_RDATA(32'hDEADBEEF)) dut (
        .clock(clock), .reset(reset),
        .imem_in(imem_in), .imem_out(imem_out), .dmem_in(dmem_in), .dmem_out(dmem_out),
        .memory_valid(memory_valid), .memory_instr(memory_instr), .memory_addr(memory_addr),
        .memory_wdata(memory_wdata), .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata),
        .memory_ready(memory_ready), .bus_error(bus_error), .overrun(overrun)
    );

    mem_rr_scheduler #(.TIMEOUT(4), .CNT_W(8), .ERR_RDATA(32'hDEADBEEF)) dut_wd (
        .clock(clock), .reset(reset),
        .imem_in(w_imem_in), .imem_out(w_imem_out), .dmem_in(w_dmem_in), .dmem_out(w_dmem_out),
        .memory_valid(w_memory_valid), .memory_instr(w_memory_instr), .memory_addr(w_memory_addr),
        .memory_wdata(w_memory_wdata), .memory_wstrb(w_memory_wstrb), .memory_rdata(w_memory_rdata),
        .memory_ready(w_memory_ready), .bus_error(w_bus_error), .overrun(w_overrun)
    );

    typedef struct {
        int          inst;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } iss_t;

    // src: 0 dut imem, 1 dut dmem, 2 dut_wd imem, 3 dut_wd dmem
    typedef struct {
        int          src;
        logic [31:0] rdata;
        logic        berr;
    } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   mem_lat = 1;
    int   age     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic mem_in_type mk_req(input logic instr, input logic [31:0] addr,
                                          input logic [31:0] wdata, input logic [3:0] wstrb);
        mem_in_type r;
        r.mem_valid = 1'b1;
        r.mem_instr = instr;
        r.mem_addr  = addr;
        r.mem_wdata = wdata;
        r.mem_wstrb = wstrb;
        return r;
    endfunction

    task automatic exp_issue(input int inst, input logic instr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb);
        iss_q.push_back('{inst, instr, addr, wdata, wstrb});
    endtask

    task automatic exp_rsp(input int src, input logic [31:0] rdata, input logic berr);
        rsp_q.push_back('{src, rdata, berr});
    endtask

    task automatic chk_issue(input int inst, input logic instr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb);
        iss_t e;
        check("issue_expected", 64'(iss_q.size() != 0), 64'd1);
        if (iss_q.size() != 0) begin
            e = iss_q.pop_front();
            check("issue_inst", 64'(inst), 64'(e.inst));
            check("issue_addr_wdata", {addr, wdata}, {e.addr, e.wdata});
            check("issue_instr_wstrb", 64'({instr, wstrb}), 64'({e.instr, e.wstrb}));
        end
    endtask

    task automatic chk_rsp(input int src, input logic [31:0] rdata, input logic berr);
        rsp_t e;
        check("rsp_expected", 64'(rsp_q.size() != 0), 64'd1);
        if (rsp_q.size() != 0) begin
            e = rsp_q.pop_front();
            check("rsp_src", 64'(src), 64'(e.src));
            check("rsp_berr_rdata", 64'({berr, rdata}), 64'({e.berr, e.rdata}));
        end
    endtask

    // Memory model for dut: ready arrives mem_lat cycles into each access, rdata = addr + 0x12345578.
    initial begin
        memory_ready = 1'b0;
        memory_rdata = '0;
        forever begin
            @(posedge clock);
            #1;
            if (reset || !memory_valid) age = 0;
            else if (memory_ready)      age = 1;
            else                        age = age + 1;
            memory_ready = memory_valid && !reset && (age == mem_lat);
            memory_rdata = memory_ready ? memory_addr + 32'h1234_5578 : 32'h0;
        end
    end

    logic m_pv = 1'b0, m_pr = 1'b0, w_pv = 1'b0, w_pr = 1'b0;

    always @(negedge clock) begin
        if (!reset) begin
            if (memory_valid && (!m_pv || m_pr))
                chk_issue(0, memory_instr, memory_addr, memory_wdata, memory_wstrb);
            if (w_memory_valid && (!w_pv || w_pr))
                chk_issue(1, w_memory_instr, w_memory_addr, w_memory_wdata, w_memory_wstrb);
            if (imem_out.mem_ready)   chk_rsp(0, imem_out.mem_rdata, bus_error);
            if (dmem_out.mem_ready)   chk_rsp(1, dmem_out.mem_rdata, bus_error);
            if (w_imem_out.mem_ready) chk_rsp(2, w_imem_out.mem_rdata, w_bus_error);
            if (w_dmem_out.mem_ready) chk_rsp(3, w_dmem_out.mem_rdata, w_bus_error);
        end
        m_pv = !reset && memory_valid;
        m_pr = !reset && memory_ready;
        w_pv = !reset && w_memory_valid;
        w_pr = !reset && w_memory_ready;
    end

    initial begin
        int cnt;
        imem_in = '0; dmem_in = '0; w_imem_in = '0; w_dmem_in = '0;
        w_memory_ready = 1'b0;
        w_memory_rdata = 32'hCAFE_0000;

        #12;
        check("rst_memory_valid", 64'(memory_valid), 64'd0);
        check("rst_memory_fields", {memory_addr, memory_wdata}, 64'd0);
        check("rst_memory_ctl", 64'({memory_instr, memory_wstrb}), 64'd0);
        check("rst_resp_out", 64'({imem_out.mem_ready, dmem_out.mem_ready}), 64'd0);
        check("rst_resp_rdata", {imem_out.mem_rdata, dmem_out.mem_rdata}, 64'd0);
        check("rst_flags", 64'({bus_error, overrun, w_bus_error, w_overrun}), 64'd0);
        check("rst_wd_valid", 64'(w_memory_valid), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Single dmem read, ready in the third BUSY cycle.
        mem_lat = 3;
        exp_issue(0, 1'b0, 32'h100, 32'h0, 4'h0);
        exp_rsp(1, 32'h1234_5678, 1'b0);
        dmem_in = mk_req(1'b0, 32'h100, 32'h0, 4'h0);
        tick(1);
        dmem_in.mem_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (memory_valid) cnt++;
            tick(1);
        end
        check("t1_valid_cycles", 64'(cnt), 64'd3);

        // Tie after a dmem access: imem wins, dmem follows with no idle cycle.
        mem_lat = 1;
        exp_issue(0, 1'b1, 32'h1000, 32'h0, 4'h0);
        exp_issue(0, 1'b0, 32'h200, 32'hAAAA_0001, 4'hF);
        exp_rsp(0, 32'h1234_6578, 1'b0);
        exp_rsp(1, 32'h1234_5778, 1'b0);
        imem_in = mk_req(1'b1, 32'h1000, 32'h0, 4'h0);
        dmem_in = mk_req(1'b0, 32'h200, 32'hAAAA_0001, 4'hF);
        tick(1);
        imem_in.mem_valid = 1'b0;
        dmem_in.mem_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) check("t2a_back_to_back", 64'({memory_valid, memory_instr}), 64'b10);
            if (memory_valid) cnt++;
            tick(1);
        end
        check("t2a_valid_cycles", 64'(cnt), 64'd2);

        // Repeat pair: dmem was served last, so imem wins again.
        exp_issue(0, 1'b1, 32'h1004, 32'h0, 4'h0);
        exp_issue(0, 1'b0, 32'h204, 32'h5555_0002, 4'h3);
        exp_rsp(0, 32'h1234_657C, 1'b0);
        exp_rsp(1, 32'h1234_577C, 1'b0);
        imem_in = mk_req(1'b1, 32'h1004, 32'h0, 4'h0);
        dmem_in = mk_req(1'b0, 32'h204, 32'h5555_0002, 4'h3);
        tick(1);
        imem_in.mem_valid = 1'b0;
        dmem_in.mem_valid = 1'b0;
        tick(6);

        // One-cycle imem pulse while dmem is busy for 5 cycles.
        mem_lat = 5;
        exp_issue(0, 1'b0, 32'h300, 32'hF00D_0003, 4'h1);
        exp_issue(0, 1'b1, 32'h1008, 32'h0, 4'h0);
        exp_rsp(1, 32'h1234_5878, 1'b0);
        exp_rsp(0, 32'h1234_6580, 1'b0);
        dmem_in = mk_req(1'b0, 32'h300, 32'hF00D_0003, 4'h1);
        tick(1);
        dmem_in.mem_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 1) imem_in = mk_req(1'b1, 32'h1008, 32'h0, 4'h0);
            if (i == 2) imem_in.mem_valid = 1'b0;
            if (i == 5) check("t3_imem_issued", 64'({memory_valid, memory_instr}), 64'b11);
            if (memory_valid) cnt++;
            tick(1);
        end
        check("t3_valid_cycles", 64'(cnt), 64'd10);
        check("t3_no_overrun", 64'(overrun), 64'd0);

        // Second dmem pulse while the first is still in flight is dropped.
        mem_lat = 4;
        exp_issue(0, 1'b0, 32'h400, 32'h0, 4'h0);
        exp_rsp(1, 32'h1234_5978, 1'b0);
        dmem_in = mk_req(1'b0, 32'h400, 32'h0, 4'h0);
        tick(1);
        dmem_in.mem_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) dmem_in = mk_req(1'b0, 32'h404, 32'h1, 4'hF);
            if (i == 2) dmem_in.mem_valid = 1'b0;
            if (i == 3) check("t4_overrun_set", 64'(overrun), 64'd1);
            tick(1);
        end
        check("t4_overrun_sticky", 64'(overrun), 64'd1);

        // Watchdog abort on dut_wd after exactly 4 BUSY cycles.
        exp_issue(1, 1'b0, 32'h500, 32'h1111_2222, 4'hC);
        exp_rsp(3, 32'hDEAD_BEEF, 1'b1);
        w_dmem_in = mk_req(1'b0, 32'h500, 32'h1111_2222, 4'hC);
        tick(1);
        w_dmem_in.mem_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) check("t5_bus_error_pulse", 64'(w_bus_error), 64'd1);
            if (i == 4) check("t5_bus_error_low", 64'(w_bus_error), 64'd0);
            if (w_memory_valid) cnt++;
            tick(1);
        end
        check("t5_busy_cycles", 64'(cnt), 64'd4);
        check("t5_valid_dropped", 64'(w_memory_valid), 64'd0);
        w_memory_ready = 1'b1;
        #1;
        check("t5_late_ready_ignored", 64'({w_imem_out.mem_ready, w_dmem_out.mem_ready, w_bus_error}), 64'd0);
        tick(1);
        w_memory_ready = 1'b0;
        tick(2);

        // Reset in mid-BUSY drops the access asynchronously; afterwards dmem wins the first tie.
        mem_lat = 6;
        exp_issue(0, 1'b0, 32'h600, 32'h0, 4'hF);
        dmem_in = mk_req(1'b0, 32'h600, 32'h0, 4'hF);
        tick(1);
        dmem_in.mem_valid = 1'b0;
        tick(2);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_valid_drop", 64'(memory_valid), 64'd0);
        check("t6_no_ready", 64'({imem_out.mem_ready, dmem_out.mem_ready}), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("t6_overrun_cleared", 64'(overrun), 64'd0);
        mem_lat = 1;
        exp_issue(0, 1'b0, 32'h700, 32'h0, 4'h0);
        exp_issue(0, 1'b1, 32'h1010, 32'h0, 4'h0);
        exp_rsp(1, 32'h1234_5C78, 1'b0);
        exp_rsp(0, 32'h1234_6588, 1'b0);
        imem_in = mk_req(1'b1, 32'h1010, 32'h0, 4'h0);
        dmem_in = mk_req(1'b0, 32'h700, 32'h0, 4'h0);
        tick(1);
        imem_in.mem_valid = 1'b0;
        dmem_in.mem_valid = 1'b0;
        tick(6);

        check("issue_queue_drained", 64'(iss_q.size()), 64'd0);
        check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
